// File: rtl/regfile_read_arbiter_pkg.sv
// Shared widths, the zero-register index and common types for the register-file read arbiter.
// Optional build macro used by this block: RF_ARB_PRIORITY0_EN.
package rf_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 64;

  // Register 31 reads as zero and is never a forwarding target.
  localparam logic [ADDR_W-1:0] XZR_IDX = 5'd31;

  typedef logic [ADDR_W-1:0]  reg_idx_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Requester-side bus of the register-file read arbiter: requests, one-hot ready, responses.
// Handshake: a read transfers in any cycle where req_valid[i] & req_ready[i]; the requester
// keeps req_valid[i]/req_addr[i] stable until then, and data returns on rsp_valid[i] one cycle later.
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 64
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/regfile_read_arbiter_rr_grant.sv
// Combinational round-robin picker: first requester at or after rr_ptr_i, wrapping.
// With RF_ARB_PRIORITY0_EN defined, requester 0 wins whenever it is requesting.
module rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_vec_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   grant_idx_o,
  output logic               grant_any_o
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    idx         = '0;
    // Walk from the farthest slot back to rr_ptr so the nearest requester overwrites last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (req_vec_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
        grant_any_o  = 1'b1;
      end
    end
`ifdef RF_ARB_PRIORITY0_EN
    if (req_vec_i[0]) begin
      grant_o     = '0;
      grant_o[0]  = 1'b1;
      grant_idx_o = '0;
      grant_any_o = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one register-file read port among NUM_REQ requesters, one read per cycle, data returned
// one cycle later with write-to-read forwarding. Build macro: RF_ARB_PRIORITY0_EN (requester 0 first).
module regfile_read_arbiter #(
  parameter int NUM_REQ = rf_arb_pkg::NUM_REQ,
  parameter int ADDR_W  = rf_arb_pkg::ADDR_W,
  parameter int DATA_W  = rf_arb_pkg::DATA_W,
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arb_en,
  output logic [ADDR_W-1:0]       rf_read_reg,
  input  logic [DATA_W-1:0]       rf_read_data,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_reg,
  input  logic [DATA_W-1:0]       wr_data,
  regfile_read_arbiter_if.slave   bus,
  output logic [PTR_W-1:0]        dbg_rr_ptr
);

  import rf_arb_pkg::*;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
`ifdef RF_ARB_PRIORITY0_EN
  // Requester 0 sits outside the rotation, so the pointer never rests on it.
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(1);
`else
  localparam logic [PTR_W-1:0] PTR_RST  = '0;
`endif

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic               issue;
  logic               bypass;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_grant (
    .req_vec_i   (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  // Ready is suppressed while reset is held, even before the first clock edge.
  assign issue         = grant_any & arb_en & reset;
  assign bus.req_ready = issue ? grant : '0;
  assign rf_read_reg   = issue ? bus.req_addr[grant_idx] : '0;

  // A same-cycle write to the selected register is forwarded; the zero register never is.
  assign bypass = wr_en && (wr_reg == rf_read_reg) && (rf_read_reg != ADDR_W'(XZR_IDX));

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (issue) begin
      rsp_valid_d = grant;
      rsp_data_d  = bypass ? wr_data : rf_read_data;
`ifdef RF_ARB_PRIORITY0_EN
      if (grant_idx != '0) begin
        rr_ptr_d = (grant_idx == LAST_IDX) ? PTR_W'(1) : grant_idx + PTR_W'(1);
      end
`else
      rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= PTR_RST;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign dbg_rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: register-file model, behavioural arbitration model with a
// response queue checked every falling edge, directed scenarios and a randomized phase.
module tb_regfile_read_arbiter;
  import rf_arb_pkg::*;

  localparam int N = NUM_REQ;
`ifdef RF_ARB_PRIORITY0_EN
  localparam int PTR_RST = 1;
`else
  localparam int PTR_RST = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk    = 1'b0;
  logic              reset  = 1'b0;
  logic              arb_en = 1'b0;
  logic              wr_en  = 1'b0;
  reg_idx_t          wr_reg = '0;
  logic [DATA_W-1:0] wr_data = '0;
  reg_idx_t          rf_read_reg;
  logic [DATA_W-1:0] rf_read_data;
  logic [1:0]        dbg_rr_ptr;

  regfile_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_read_arbiter #(.NUM_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .arb_en       (arb_en),
    .rf_read_reg  (rf_read_reg),
    .rf_read_data (rf_read_data),
    .wr_en        (wr_en),
    .wr_reg       (wr_reg),
    .wr_data      (wr_data),
    .bus          (bus),
    .dbg_rr_ptr   (dbg_rr_ptr)
  );

  always #5 clk = ~clk;

  // ---------------- register file environment ----------------
  logic [DATA_W-1:0] mem [32];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= (i == 31) ? '0 : {32'hC0DE_0000 | 32'(i), 32'(i) * 32'h1234_5677};
    end else if (wr_en && wr_reg != XZR_IDX) begin
      mem[wr_reg] <= wr_data;
    end
  end

  assign rf_read_data = (rf_read_reg == XZR_IDX) ? '0 : mem[rf_read_reg];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  int                m_ptr   = PTR_RST;
  int                m_grant = -1;
  logic [DATA_W-1:0] exp_q[$];
  int                exp_idx_q[$];
  int                grant_log[$];

  int                c_g;
  reg_idx_t          c_a;
  logic [DATA_W-1:0] c_d;

  function automatic int pick();
    if (!arb_en) return -1;
`ifdef RF_ARB_PRIORITY0_EN
    if (bus.req_valid[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic int logged(input int pos);
    if (pos < grant_log.size()) return grant_log[pos];
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check("ready_in_reset", 64'(bus.req_ready), 64'd0);
      check("rsp_valid_in_reset", 64'(bus.rsp_valid), 64'd0);
      check("read_reg_in_reset", 64'(rf_read_reg), 64'd0);
      check("rr_ptr_in_reset", 64'(dbg_rr_ptr), 64'(PTR_RST));
      exp_q.delete();
      exp_idx_q.delete();
      m_ptr   = PTR_RST;
      m_grant = -1;
    end else begin
      check("rr_ptr", 64'(dbg_rr_ptr), 64'(m_ptr));
      if (exp_q.size() > 0) begin
        check("rsp_valid", 64'(bus.rsp_valid), 64'd1 << exp_idx_q[0]);
        check("rsp_data", bus.rsp_data, exp_q[0]);
        void'(exp_q.pop_front());
        void'(exp_idx_q.pop_front());
      end else begin
        check("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
      end
      c_g = pick();
      c_a = (c_g >= 0) ? bus.req_addr[c_g] : '0;
      check("req_ready", 64'(bus.req_ready), (c_g >= 0) ? (64'd1 << c_g) : 64'd0);
      check("rf_read_reg", 64'(rf_read_reg), 64'(c_a));
      if (c_g >= 0) begin
        if (c_a == XZR_IDX)                 c_d = '0;
        else if (wr_en && wr_reg == c_a)    c_d = wr_data;
        else                                c_d = mem[c_a];
        exp_q.push_back(c_d);
        exp_idx_q.push_back(c_g);
        grant_log.push_back(c_g);
`ifdef RF_ARB_PRIORITY0_EN
        if (c_g != 0) begin
          m_ptr = (c_g + 1) % N;
          if (m_ptr == 0) m_ptr = 1;
        end
`else
        m_ptr = (c_g + 1) % N;
`endif
      end
      m_grant = c_g;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.req_valid = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  function automatic reg_idx_t rand_addr();
    if ($urandom_range(0, 7) == 0) return XZR_IDX;
    return reg_idx_t'($urandom_range(0, 7));
  endfunction

  int base;
  int exp_g;

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    arb_en        = 1'b1;
    do_reset();

    // reset dropped while a response is on the bus
    bus.req_valid = 4'b0001;
    bus.req_addr[0] = 5'd5;
    tick();
    check("t1_rsp_before_reset", 64'(bus.rsp_valid), 64'b0001);
    bus.req_valid = '0;
    reset = 1'b0;
    #1;
    check("t1_rsp_dropped", 64'(bus.rsp_valid), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    bus.req_valid = 4'b0001;
    bus.req_addr[0] = 5'd5;
    #1;
    check("t1_ready", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = '0;
    check("t1_rsp_valid", 64'(bus.rsp_valid), 64'b0001);
    check("t1_rsp_x5", bus.rsp_data, 64'hC0DE_0005_5B05_B053);
    tick();

    // all requesting: rotation
    do_reset();
    base = grant_log.size();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < N; i++) bus.req_addr[i] = reg_idx_t'(i + 1);
    repeat (8) tick();
    bus.req_valid = '0;
    tick();
    for (int k = 0; k < 8; k++) begin
`ifdef RF_ARB_PRIORITY0_EN
      exp_g = 0;
`else
      exp_g = k % 4;
`endif
      check("t2_grant_order", 64'(logged(base + k)), 64'(exp_g));
    end

    // sparse requesters 1 and 3
    do_reset();
    base = grant_log.size();
    bus.req_valid = 4'b1010;
    repeat (3) begin
      #1;
      check("t3_idle_never_ready", 64'(bus.req_ready & 4'b0101), 64'd0);
      tick();
    end
    bus.req_valid = '0;
    tick();
    check("t3_grant0", 64'(logged(base)),     64'd1);
    check("t3_grant1", 64'(logged(base + 1)), 64'd3);
    check("t3_grant2", 64'(logged(base + 2)), 64'd1);

    // forwarding of a same-cycle write, never for register 31
    bus.req_valid = 4'b0100;
    bus.req_addr[2] = 5'd7;
    wr_en = 1'b1; wr_reg = 5'd7; wr_data = 64'hDEAD_BEEF;
    tick();
    bus.req_valid = '0; wr_en = 1'b0;
    check("t4_bypass_data", bus.rsp_data, 64'hDEAD_BEEF);
    bus.req_valid = 4'b0100;
    bus.req_addr[2] = XZR_IDX;
    wr_en = 1'b1; wr_reg = XZR_IDX; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.req_valid = '0; wr_en = 1'b0;
    check("t4_xzr_data", bus.rsp_data, 64'd0);

    // arbitration disabled right after a grant
    bus.req_valid = 4'b0001;
    bus.req_addr[0] = 5'd3;
    tick();
    arb_en = 1'b0;
    bus.req_valid = 4'b1111;
    check("t5_rsp_after_disable", 64'(bus.rsp_valid), 64'b0001);
    repeat (3) begin
      #1;
      check("t5_ready_off", 64'(bus.req_ready), 64'd0);
      tick();
    end
    base = grant_log.size();
    arb_en = 1'b1;
    tick();
    bus.req_valid = '0;
    tick();
`ifdef RF_ARB_PRIORITY0_EN
    check("t5_resume_grant", 64'(logged(base)), 64'd0);
`else
    check("t5_resume_grant", 64'(logged(base)), 64'd1);
`endif

`ifdef RF_ARB_PRIORITY0_EN
    do_reset();
    base = grant_log.size();
    bus.req_valid = 4'b1111;
    repeat (4) tick();
    bus.req_valid = 4'b1110;
    repeat (4) tick();
    bus.req_valid = '0;
    tick();
    for (int k = 0; k < 4; k++) check("t6_prio0", 64'(logged(base + k)), 64'd0);
    check("t6_rot0", 64'(logged(base + 4)), 64'd1);
    check("t6_rot1", 64'(logged(base + 5)), 64'd2);
    check("t6_rot2", 64'(logged(base + 6)), 64'd3);
    check("t6_rot3", 64'(logged(base + 7)), 64'd1);
`endif

    // randomized traffic: requesters hold until granted, writes collide with reads
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && m_grant == i) begin
          bus.req_valid[i] = 1'($urandom_range(0, 1));
          bus.req_addr[i]  = rand_addr();
        end else if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
          bus.req_valid[i] = 1'b1;
          bus.req_addr[i]  = rand_addr();
        end
      end
      arb_en  = ($urandom_range(0, 9) != 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_reg  = rand_addr();
      wr_data = {$urandom, $urandom};
      reset   = ($urandom_range(0, 149) != 0);
      tick();
    end
    reset = 1'b1;
    bus.req_valid = '0;
    wr_en = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
